// File: rtl/gigatron_pkg.sv
// Shared constants for the Famicom pad emulator: button bit positions,
// PS/2 set-2 scancodes, the pad state machine encoding and the key map.
package gigatron_pkg;

  // Button bit positions in the active-high vector {A,B,Sel,Start,Up,Down,Left,Right}
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  // Set-2 scancodes; the arrow keys are only valid with the E0 (extended) prefix
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_TAB   = 8'h0D;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Number of serial bits in one pad read
  localparam logic [3:0] PAD_BITS = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } pad_state_t;

  // One-hot button mask for a key; zero for unmapped keys or a wrong prefix
  function automatic logic [7:0] key_mask(input logic ext, input logic [7:0] code);
    logic [7:0] mask;
    mask = 8'h00;
    if (!ext) begin
      case (code)
        SC_X:     mask[BTN_A]      = 1'b1;
        SC_Z:     mask[BTN_B]      = 1'b1;
        SC_TAB:   mask[BTN_SELECT] = 1'b1;
        SC_ENTER: mask[BTN_START]  = 1'b1;
        default:  mask = 8'h00;
      endcase
    end else begin
      case (code)
        SC_UP:    mask[BTN_UP]    = 1'b1;
        SC_DOWN:  mask[BTN_DOWN]  = 1'b1;
        SC_LEFT:  mask[BTN_LEFT]  = 1'b1;
        SC_RIGHT: mask[BTN_RIGHT] = 1'b1;
        default:  mask = 8'h00;
      endcase
    end
    return mask;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous strobe, followed by a history
// flop so the synchronised level's rising edge can be detected.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the raw strobe through the synchroniser chain and remember the last synced level
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/famicom_pad_emu.sv
// Famicom serial pad emulator: tracks PS/2 key presses, merges in the
// hps_io joystick, and serialises the buttons on latch/pulse strobes.
module famicom_pad_emu
  import gigatron_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit JOY_ENABLE  = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  joystick,
  input  logic        famicom_latch,
  input  logic        famicom_pulse,
  output logic        famicom_data,
  output logic [7:0]  buttons_dbg
);

  logic       latch_level, latch_rise_unused;
  logic       pulse_level_unused, pulse_rise;

  logic [7:0] key_state_q, key_state_d;
  logic       toggle_q;
  logic [7:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  pad_state_t state_q, state_d;
  logic       data_q, data_d;
  logic [7:0] dbg_q;
  logic [7:0] joy_btn;
  logic [7:0] btn;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .async_i (famicom_latch),
    .level_o (latch_level),
    .rise_o  (latch_rise_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .async_i (famicom_pulse),
    .level_o (pulse_level_unused),
    .rise_o  (pulse_rise)
  );

  // Joystick word reordered into the pad's {A,B,Sel,Start,Up,Down,Left,Right} layout
  assign joy_btn = JOY_ENABLE ? {joystick[4], joystick[5], joystick[6], joystick[7],
                                 joystick[3:0]} : 8'h00;
  assign btn     = key_state_q | joy_btn;

  // A toggle of ps2_key[10] is one key event; mapped keys set or clear their button bit
  always_comb begin
    logic [7:0] mask;
    key_state_d = key_state_q;
    mask        = key_mask(ps2_key[8], ps2_key[7:0]);
    if (ps2_key[10] != toggle_q) begin
      key_state_d = ps2_key[9] ? (key_state_q | mask) : (key_state_q & ~mask);
    end
  end

  // Pad sequencing: latch reloads from live buttons and wins over any pulse
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (latch_level) begin
      state_d = LOAD;
      shift_d = ~btn;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        LOAD:    state_d = SHIFT;
        SHIFT: begin
          if (pulse_rise && (cnt_q < PAD_BITS)) begin
            shift_d = {shift_q[6:0], 1'b1};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_d == PAD_BITS) begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // The serial line only carries shift data while a read is in progress
  always_comb begin
    data_d = 1'b1;
    if ((state_q == LOAD) || (state_q == SHIFT)) begin
      data_d = shift_q[7];
    end
  end

  // State, key tracking and registered outputs
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      key_state_q <= 8'h00;
      toggle_q    <= ps2_key[10];
      shift_q     <= 8'hFF;
      cnt_q       <= 4'd0;
      state_q     <= IDLE;
      data_q      <= 1'b1;
      dbg_q       <= 8'h00;
    end else begin
      key_state_q <= key_state_d;
      toggle_q    <= ps2_key[10];
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      data_q      <= data_d;
      dbg_q       <= btn;
    end
  end

  assign famicom_data = data_q;
  assign buttons_dbg  = dbg_q;

endmodule

// File: tb/tb_famicom_pad_emu.sv
// Directed testbench for famicom_pad_emu: key/joystick mapping, serial reads,
// latch abort, stray pulses in IDLE and reset mid-read.
module tb_famicom_pad_emu;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [7:0]  joystick;
  logic        famicom_latch;
  logic        famicom_pulse;
  logic        famicom_data;
  logic [7:0]  buttons_dbg;

  int   checks = 0;
  int   passes = 0;
  logic tgl    = 1'b0;

  // Key table: {ext, code} and the expected one-hot button
  logic [8:0] kc [8] = '{9'h022, 9'h01A, 9'h00D, 9'h05A, 9'h175, 9'h172, 9'h16B, 9'h174};
  logic [7:0] km [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  // Joystick word and the expected button vector
  logic [7:0] jw [4] = '{8'h10, 8'h80, 8'h0C, 8'h20};
  logic [7:0] jb [4] = '{8'h80, 8'h10, 8'h0C, 8'h40};

  always #5 clk_sys = ~clk_sys;

  famicom_pad_emu #(.SYNC_STAGES(2), .JOY_ENABLE(1'b1)) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ps2_key       (ps2_key),
    .joystick      (joystick),
    .famicom_latch (famicom_latch),
    .famicom_pulse (famicom_pulse),
    .famicom_data  (famicom_data),
    .buttons_dbg   (buttons_dbg)
  );

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    tgl     = ~tgl;
    ps2_key = {tgl, pressed, ext, code};
    cycles(4);
  endtask

  task automatic do_latch();
    famicom_latch = 1'b1;
    cycles(20);
    famicom_latch = 1'b0;
    cycles(10);
  endtask

  task automatic do_pulse();
    famicom_pulse = 1'b1;
    cycles(10);
    famicom_pulse = 1'b0;
    cycles(10);
  endtask

  // Full pad read: latch, eight bits (checked before each pulse), then the idle-high tail
  task automatic read_seq(input string tag, input logic [7:0] exp_bits);
    do_latch();
    for (int i = 0; i < 8; i++) begin
      check8($sformatf("%s_bit%0d", tag, i), {7'b0, famicom_data}, {7'b0, exp_bits[7-i]});
      do_pulse();
    end
    check8($sformatf("%s_after8", tag), {7'b0, famicom_data}, 8'h01);
    do_pulse();
    check8($sformatf("%s_after9", tag), {7'b0, famicom_data}, 8'h01);
    $display("read %s expected_bits=%b", tag, exp_bits);
  endtask

  initial begin
    reset_n       = 1'b0;
    ps2_key       = 11'h000;
    joystick      = 8'h00;
    famicom_latch = 1'b0;
    famicom_pulse = 1'b0;
    cycles(3);
    check8("reset_data", {7'b0, famicom_data}, 8'h01);
    check8("reset_dbg", buttons_dbg, 8'h00);
    $display("reset checked");
    reset_n = 1'b1;
    cycles(2);

    // Idle pad reads all released
    read_seq("idle_read", 8'hFF);

    // Every mapped key sets and clears only its own bit
    for (int k = 0; k < 8; k++) begin
      send_key(1'b1, kc[k][8], kc[k][7:0]);
      check8($sformatf("key%0d_press", k), buttons_dbg, km[k]);
      send_key(1'b0, kc[k][8], kc[k][7:0]);
      check8($sformatf("key%0d_release", k), buttons_dbg, 8'h00);
      $display("key %h ext=%0d checked", kc[k][7:0], kc[k][8]);
    end

    // Joystick bit reordering
    for (int j = 0; j < 4; j++) begin
      joystick = jw[j];
      cycles(3);
      check8($sformatf("joy%0d", j), buttons_dbg, jb[j]);
      $display("joystick %h checked", jw[j]);
    end
    joystick = 8'h00;

    // X held plus joystick right
    send_key(1'b1, 1'b0, 8'h22);
    joystick = 8'h01;
    cycles(3);
    check8("x_joy_dbg", buttons_dbg, 8'h81);
    read_seq("x_joy_read", 8'h7E);
    joystick = 8'h00;
    cycles(3);

    // Extended up press/release, then a non-extended 0x75 that must be ignored
    send_key(1'b1, 1'b1, 8'h75);
    check8("ext_up_press", buttons_dbg, 8'h88);
    send_key(1'b0, 1'b1, 8'h75);
    check8("ext_up_release", buttons_dbg, 8'h80);
    send_key(1'b1, 1'b0, 8'h75);
    check8("kp8_ignored", buttons_dbg, 8'h80);
    send_key(1'b0, 1'b0, 8'h22);
    send_key(1'b1, 1'b0, 8'h5A);
    check8("start_only", buttons_dbg, 8'h10);

    // Latch after three pulses aborts and restarts from the A bit
    do_latch();
    for (int i = 0; i < 3; i++) begin
      check8($sformatf("abort_bit%0d", i), {7'b0, famicom_data}, 8'h01);
      do_pulse();
    end
    $display("partial read aborted after 3 pulses");
    read_seq("reload_read", 8'hEF);

    // Reset mid-shift with X held
    send_key(1'b1, 1'b0, 8'h22);
    check8("x_start_dbg", buttons_dbg, 8'h90);
    do_latch();
    check8("pre_reset_bit0", {7'b0, famicom_data}, 8'h00);
    do_pulse();
    do_pulse();
    reset_n = 1'b0;
    cycles(1);
    check8("midreset_data", {7'b0, famicom_data}, 8'h01);
    check8("midreset_dbg", buttons_dbg, 8'h00);
    reset_n = 1'b1;
    $display("reset mid-shift checked");
    cycles(2);

    // Pulses with no latch leave the line high
    for (int i = 0; i < 3; i++) begin
      do_pulse();
      check8($sformatf("idle_pulse%0d", i), {7'b0, famicom_data}, 8'h01);
    end
    $display("stray pulses in idle checked");
    read_seq("post_reset_read", 8'hFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
